mux_frame_sequencer: RTL and testbench

- Upstream controller for the team's 4:1 bit-select mux.
- Accepts 4-bit words over a valid/ready handshake and drives the mux data (d_out) and select (sel_out) to serialise each word as one bit per slot.
- Each bit is held for BIT_DIV cycles; a one-word pending buffer gives gap-free back-to-back frames.
- Samples the mux output (y_in) at the end of every bit slot and flags any mismatch against the expected bit, as a loopback check of the mux path.

---
 rtl/mux_frame_sequencer.sv | 155 +++++++++++++++
 tb/tb_mux_frame_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_frame_sequencer.sv
// ---------------------------------------------------------------------------
// mux_frame_sequencer
//
// Upstream controller for the 4:1 bit-select mux. Accepts 4-bit words over a
// valid/ready handshake, then walks the mux select across all four bits of
// the word, holding each bit for BIT_DIV cycles. A one-word pending buffer
// lets the next word start on the cycle straight after the previous frame's
// last slot. The mux output is looped back on y_in and compared against the
// expected bit at the end of every slot; any disagreement sets a sticky err.
//
// Parameters
//   BIT_DIV    cycles each bit is held on sel_out (1..255)
//   MSB_FIRST  0: select order 0,1,2,3   1: select order 3,2,1,0
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   in_data carries a word
//   in_ready     out  pending buffer is empty, a word can be taken
//   in_data      in   word to serialise
//   d_out        out  data bus to the mux d input (changes only on load)
//   sel_out      out  select to the mux sel input (changes only at slot ends)
//   y_in         in   mux output fed back for checking
//   busy         out  a frame is in progress
//   frame_start  out  one-cycle pulse, first cycle of a frame
//   bit_strobe   out  one-cycle pulse, last cycle of each bit slot
//   frame_done   out  one-cycle pulse, last cycle of the last bit slot
//   err_clr      in   clears err (a same-cycle mismatch takes priority)
//   err          out  sticky loopback mismatch flag
// ---------------------------------------------------------------------------
module mux_frame_sequencer #(
    parameter int unsigned BIT_DIV   = 1,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic [3:0] d_out,
    output logic [1:0] sel_out,
    input  logic       y_in,
    output logic       busy,
    output logic       frame_start,
    output logic       bit_strobe,
    output logic       frame_done,
    input  logic       err_clr,
    output logic       err
);

    localparam logic [7:0] DIV_LAST  = 8'(BIT_DIV - 1);
    localparam logic [1:0] SEL_FIRST = MSB_FIRST ? 2'd3 : 2'd0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t     state_q;
    logic [3:0] pend_q;
    logic       pend_v_q;
    logic [1:0] bit_cnt_q;
    logic [7:0] div_q;
    logic [3:0] d_q;
    logic [1:0] sel_q;
    logic       frame_start_q;
    logic       err_q;

    // Decodes of the registered state; none of these depend on inputs
    // except the handshake accept and the loopback compare.
    logic       slot_end;
    logic       last_slot_end;
    logic       load;
    logic       accept;
    logic [1:0] sel_d;
    logic       exp_bit;
    logic       mismatch;

    always_comb begin
        slot_end      = (state_q == SHIFT) && (div_q == DIV_LAST);
        last_slot_end = slot_end && (bit_cnt_q == 2'd3);
        // A word is launched either from idle or exactly on the last cycle
        // of the running frame, which is what makes frames gap-free.
        load          = pend_v_q && ((state_q == IDLE) || last_slot_end);
        // in_ready is !pend_v_q, so a word can never be accepted and loaded
        // on the same edge; the two updates of pend_v_q are exclusive.
        accept        = in_valid && !pend_v_q;
        sel_d         = MSB_FIRST ? (sel_q - 2'd1) : (sel_q + 2'd1);
        exp_bit       = d_q[sel_q];
        mismatch      = slot_end && (y_in != exp_bit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pend_q        <= 4'd0;
            pend_v_q      <= 1'b0;
            bit_cnt_q     <= 2'd0;
            div_q         <= 8'd0;
            d_q           <= 4'd0;
            sel_q         <= 2'd0;
            frame_start_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            frame_start_q <= load;

            // Pending buffer
            if (accept) begin
                pend_q   <= in_data;
                pend_v_q <= 1'b1;
            end else if (load) begin
                pend_v_q <= 1'b0;
            end

            // Frame sequencing
            if (load) begin
                d_q       <= pend_q;
                sel_q     <= SEL_FIRST;
                bit_cnt_q <= 2'd0;
                div_q     <= 8'd0;
                state_q   <= SHIFT;
            end else if (state_q == SHIFT) begin
                if (slot_end) begin
                    div_q <= 8'd0;
                    if (bit_cnt_q == 2'd3) begin
                        // No word waiting: park with d_out/sel_out held.
                        state_q <= IDLE;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 2'd1;
                        sel_q     <= sel_d;
                    end
                end else begin
                    div_q <= div_q + 8'd1;
                end
            end

            // Loopback check; a mismatch beats a simultaneous clear.
            if (mismatch) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign in_ready    = !pend_v_q;
    assign d_out       = d_q;
    assign sel_out     = sel_q;
    assign busy        = (state_q == SHIFT);
    assign frame_start = frame_start_q;
    assign bit_strobe  = slot_end;
    assign frame_done  = last_slot_end;
    assign err         = err_q;

endmodule

// File: tb/tb_mux_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mux_frame_sequencer
//
// Two sequencer instances share clock and reset: "a" with BIT_DIV=1 and LSB
// first, "b" with BIT_DIV=3 and MSB first. Each drives an ideal mux model
// (a's loopback can be forced to 0). Accepted words push the expected word
// and the expected per-cycle select sequence into queues; a negedge monitor
// pops them as frames run. Directed steps check timing, back-to-back
// behaviour, the sticky error and reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_mux_frame_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       a_in_valid, a_in_ready, a_y, a_busy, a_fs, a_bs, a_fd, a_err_clr, a_err;
    logic [3:0] a_in_data, a_d;
    logic [1:0] a_sel;
    logic       a_fault;

    logic       b_in_valid, b_in_ready, b_y, b_busy, b_fs, b_bs, b_fd, b_err_clr, b_err;
    logic [3:0] b_in_data, b_d;
    logic [1:0] b_sel;

    assign a_y = a_fault ? 1'b0 : a_d[a_sel];
    assign b_y = b_d[b_sel];

    mux_frame_sequencer #(.BIT_DIV(1), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .d_out(a_d), .sel_out(a_sel), .y_in(a_y),
        .busy(a_busy), .frame_start(a_fs), .bit_strobe(a_bs), .frame_done(a_fd),
        .err_clr(a_err_clr), .err(a_err)
    );

    mux_frame_sequencer #(.BIT_DIV(3), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .d_out(b_d), .sel_out(b_sel), .y_in(b_y),
        .busy(b_busy), .frame_start(b_fs), .bit_strobe(b_bs), .frame_done(b_fd),
        .err_clr(b_err_clr), .err(b_err)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] a_word_q[$];
    logic [1:0] a_sel_exp[$];
    logic [3:0] b_word_q[$];
    logic [1:0] b_sel_exp[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge. Returns just after the accepting posedge.
    task automatic send_a(input logic [3:0] w);
        logic rdy;
        bit   done;
        done = 1'b0;
        a_in_valid = 1'b1;
        a_in_data  = w;
        for (int i = 0; i < 40 && !done; i++) begin
            rdy = a_in_ready;
            @(posedge clk);
            if (rdy) begin
                done = 1'b1;
                a_word_q.push_back(w);
                for (int k = 0; k < 4; k++) a_sel_exp.push_back(2'(k));
            end else begin
                @(negedge clk);
            end
        end
        n_vec++;
        assert (done) else begin
            n_err++;
            $error("FAIL a_accept_timeout observed=0 expected=1");
        end
    endtask

    task automatic send_b(input logic [3:0] w);
        logic rdy;
        bit   done;
        done = 1'b0;
        b_in_valid = 1'b1;
        b_in_data  = w;
        for (int i = 0; i < 40 && !done; i++) begin
            rdy = b_in_ready;
            @(posedge clk);
            if (rdy) begin
                done = 1'b1;
                b_word_q.push_back(w);
                for (int k = 0; k < 4; k++)
                    for (int r = 0; r < 3; r++) b_sel_exp.push_back(2'(3 - k));
            end else begin
                @(negedge clk);
            end
        end
        n_vec++;
        assert (done) else begin
            n_err++;
            $error("FAIL b_accept_timeout observed=0 expected=1");
        end
    endtask

    task automatic wait_idle_a();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!a_busy) break;
        end
        chk("a_idle_timeout", 8'(a_busy), 8'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_fs) begin
                n_vec++;
                assert (a_word_q.size() > 0) else begin
                    n_err++;
                    $error("FAIL a_word_q_empty observed=frame_start expected=no_frame");
                end
                if (a_word_q.size() > 0) chk("a_frame_word", 8'(a_d), 8'(a_word_q.pop_front()));
            end
            if (a_busy) begin
                n_vec++;
                assert (a_sel_exp.size() > 0) else begin
                    n_err++;
                    $error("FAIL a_sel_q_empty observed=busy expected=idle");
                end
                if (a_sel_exp.size() > 0) chk("a_sel_seq", 8'(a_sel), 8'(a_sel_exp.pop_front()));
            end
            if (b_fs) begin
                n_vec++;
                assert (b_word_q.size() > 0) else begin
                    n_err++;
                    $error("FAIL b_word_q_empty observed=frame_start expected=no_frame");
                end
                if (b_word_q.size() > 0) chk("b_frame_word", 8'(b_d), 8'(b_word_q.pop_front()));
            end
            if (b_busy) begin
                n_vec++;
                assert (b_sel_exp.size() > 0) else begin
                    n_err++;
                    $error("FAIL b_sel_q_empty observed=busy expected=idle");
                end
                if (b_sel_exp.size() > 0) chk("b_sel_seq", 8'(b_sel), 8'(b_sel_exp.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd_idx;
        int fs_idx;

        rst_n      = 1'b0;
        a_in_valid = 1'b0; a_in_data = 4'd0; a_err_clr = 1'b0; a_fault = 1'b0;
        b_in_valid = 1'b0; b_in_data = 4'd0; b_err_clr = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_d",        8'(a_d),        8'd0);
        chk("rst_sel",      8'(a_sel),      8'd0);
        chk("rst_busy",     8'(a_busy),     8'd0);
        chk("rst_fs",       8'(a_fs),       8'd0);
        chk("rst_bs",       8'(a_bs),       8'd0);
        chk("rst_fd",       8'(a_fd),       8'd0);
        chk("rst_err",      8'(a_err),      8'd0);
        chk("rst_ready_a",  8'(a_in_ready), 8'd1);
        chk("rst_ready_b",  8'(b_in_ready), 8'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single word 1010, BIT_DIV=1, LSB first
        send_a(4'b1010);
        @(negedge clk);
        a_in_valid = 1'b0;
        chk("t1_ready_pend", 8'(a_in_ready), 8'd0);
        chk("t1_busy_pend",  8'(a_busy),     8'd0);
        chk("t1_fs_pend",    8'(a_fs),       8'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_fs",  8'(a_fs),  8'(k == 0));
            chk("t1_bs",  8'(a_bs),  8'd1);
            chk("t1_fd",  8'(a_fd),  8'(k == 3));
            chk("t1_sel", 8'(a_sel), 8'(k));
            chk("t1_d",   8'(a_d),   8'hA);
        end
        @(negedge clk);
        chk("t1_busy_end",  8'(a_busy),     8'd0);
        chk("t1_err",       8'(a_err),      8'd0);
        chk("t1_bs_end",    8'(a_bs),       8'd0);
        chk("t1_ready_end", 8'(a_in_ready), 8'd1);
        chk("t1_d_hold",    8'(a_d),        8'hA);
        chk("t1_sel_hold",  8'(a_sel),      8'd3);

        // 2: word C, BIT_DIV=3, MSB first
        send_b(4'hC);
        @(negedge clk);
        b_in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk("t2_bs",   8'(b_bs),   8'((c % 3) == 0));
            chk("t2_fd",   8'(b_fd),   8'(c == 12));
            chk("t2_busy", 8'(b_busy), 8'd1);
            chk("t2_sel",  8'(b_sel),  8'(3 - (c - 1) / 3));
        end
        @(negedge clk);
        chk("t2_busy_end", 8'(b_busy), 8'd0);
        chk("t2_err",      8'(b_err),  8'd0);

        // 3: back-to-back 5 then 9 with in_valid held
        send_a(4'h5);
        @(negedge clk);
        a_in_data = 4'h9;
        chk("t3_ready_full", 8'(a_in_ready), 8'd0);
        send_a(4'h9);
        @(negedge clk);
        a_in_valid = 1'b0;
        fd_idx = -1;
        fs_idx = -1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 0) chk("t3_ready_low", 8'(a_in_ready), 8'd0);
            if (a_fd && fd_idx < 0) fd_idx = i;
            if (a_fs && fd_idx >= 0 && fs_idx < 0) begin
                fs_idx = i;
                chk("t3_busy_gapless", 8'(a_busy), 8'd1);
            end
        end
        chk("t3_gap",      8'(fs_idx - fd_idx), 8'd1);
        chk("t3_busy_end", 8'(a_busy),          8'd0);
        chk("t3_d_last",   8'(a_d),             8'h9);

        // 4: loopback fault, sticky err, clear, set-beats-clear
        a_fault = 1'b1;
        send_a(4'hF);
        @(negedge clk);
        a_in_valid = 1'b0;
        chk("t4_err_pend", 8'(a_err), 8'd0);
        @(negedge clk);
        chk("t4_bs_first", 8'(a_bs),  8'd1);
        chk("t4_err_pre",  8'(a_err), 8'd0);
        @(negedge clk);
        chk("t4_err_set",  8'(a_err), 8'd1);
        wait_idle_a();
        a_fault = 1'b0;
        send_a(4'h6);
        @(negedge clk);
        a_in_valid = 1'b0;
        wait_idle_a();
        chk("t4_err_sticky", 8'(a_err), 8'd1);
        a_err_clr = 1'b1;
        @(negedge clk);
        a_err_clr = 1'b0;
        chk("t4_err_clr", 8'(a_err), 8'd0);
        a_fault = 1'b1;
        send_a(4'hF);
        @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        a_err_clr = 1'b1;
        @(negedge clk);
        a_err_clr = 1'b0;
        chk("t4_set_wins", 8'(a_err), 8'd1);
        wait_idle_a();
        a_fault   = 1'b0;
        a_err_clr = 1'b1;
        @(negedge clk);
        a_err_clr = 1'b0;
        chk("t4_err_clr2", 8'(a_err), 8'd0);

        // 5: reset in the second slot with a word pending
        send_a(4'h3);
        @(negedge clk);
        a_in_data = 4'hE;
        send_a(4'hE);
        #1;
        rst_n      = 1'b0;
        a_in_valid = 1'b0;
        a_sel_exp.delete();
        a_word_q.delete();
        #1;
        chk("t5_d",     8'(a_d),        8'd0);
        chk("t5_sel",   8'(a_sel),      8'd0);
        chk("t5_busy",  8'(a_busy),     8'd0);
        chk("t5_fs",    8'(a_fs),       8'd0);
        chk("t5_bs",    8'(a_bs),       8'd0);
        chk("t5_fd",    8'(a_fd),       8'd0);
        chk("t5_ready", 8'(a_in_ready), 8'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_fd_hold", 8'(a_fd),   8'd0);
            chk("t5_busy_hold", 8'(a_busy), 8'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_ready_post", 8'(a_in_ready), 8'd1);
        send_a(4'h7);
        @(negedge clk);
        a_in_valid = 1'b0;
        chk("t5_no_stale", 8'(a_busy), 8'd0);
        @(negedge clk);
        chk("t5_fs_new",  8'(a_fs),   8'd1);
        chk("t5_sel_new", 8'(a_sel),  8'd0);
        chk("t5_d_new",   8'(a_d),    8'h7);
        wait_idle_a();

        @(negedge clk);
        chk("a_sel_q_left",  8'(a_sel_exp.size()), 8'd0);
        chk("a_word_q_left", 8'(a_word_q.size()),  8'd0);
        chk("b_sel_q_left",  8'(b_sel_exp.size()), 8'd0);
        chk("b_word_q_left", 8'(b_word_q.size()),  8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
